// File: rtl/seq_divmod.sv
`default_nettype none
// ============================================================================
// Module   : seq_divmod
// Brief    : Multi-cycle unsigned restoring divider. Produces quotient and
//            remainder together after DATAWIDTH iterations with a
//            start/busy/done handshake. Divide-by-zero skips the iterations
//            and returns quot = all ones, rem = dividend.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divmod #(
    parameter int DATAWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int c_CNT_W = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_last;
    logic                 r_zero_pend;    // accepted b == 0, result due next edge
    logic [DATAWIDTH-1:0] r_dividend;     // shifts dividend out, quotient bits in
    logic [DATAWIDTH-1:0] r_divisor;
    logic [DATAWIDTH:0]   r_partial;
    logic [c_CNT_W-1:0]   r_count;
    logic [DATAWIDTH:0]   w_partial_sh;
    logic [DATAWIDTH+1:0] w_trial;
    logic                 w_qbit;
    logic [DATAWIDTH:0]   w_partial_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs. While a divide-by-zero
    // result is pending, start is not accepted so that result is delivered.
    always_comb begin
        w_next_state = r_state;
        w_accept     = start && !r_zero_pend &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last       = (r_count == c_CNT_W'(1));
        busy         = (r_state == S_CALC);
        done         = (r_state == S_DONE);
        case (r_state)
            S_CALC: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                if (r_zero_pend) begin
                    w_next_state = S_DONE;
                end else if (w_accept) begin
                    w_next_state = (b == '0) ? S_IDLE : S_CALC;
                end
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor and keep the difference only if it did not borrow.
    always_comb begin
        w_partial_sh  = {r_partial[DATAWIDTH-1:0], r_dividend[DATAWIDTH-1]};
        w_trial       = {1'b0, w_partial_sh} - {2'b00, r_divisor};
        w_qbit        = ~w_trial[DATAWIDTH+1];
        w_partial_nxt = w_qbit ? w_trial[DATAWIDTH:0] : w_partial_sh;
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_pend <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_partial   <= '0;
            r_count     <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_zero_pend <= w_accept && (b == '0);
            if (w_accept) begin
                r_dividend <= a;
                r_divisor  <= b;
                r_partial  <= '0;
                r_count    <= c_CNT_W'(DATAWIDTH);
            end else if (r_state == S_CALC) begin
                r_dividend <= {r_dividend[DATAWIDTH-2:0], w_qbit};
                r_partial  <= w_partial_nxt;
                r_count    <= r_count - c_CNT_W'(1);
                if (w_last) begin
                    quot        <= {r_dividend[DATAWIDTH-2:0], w_qbit};
                    rem         <= w_partial_nxt[DATAWIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end else if (r_zero_pend) begin
                quot        <= '1;
                rem         <= r_dividend;
                div_by_zero <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divmod.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divmod
// Brief    : Self-checking bench for seq_divmod at DATAWIDTH 4 and 8.
//            Expected results are queued at stimulus time and compared when
//            done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divmod;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;
    logic [3:0] quot4, rem4;
    logic [7:0] quot8, rem8;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   npush4 = 0, npush8 = 0, ndone4 = 0, ndone8 = 0;
    exp_t q4[$];
    exp_t q8[$];
    int   done_cycs[$];

    seq_divmod #(.DATAWIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .quot(quot4), .rem(rem4),
        .div_by_zero(dbz4)
    );

    seq_divmod #(.DATAWIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quot(quot8), .rem(rem8),
        .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int w, input logic [7:0] ta, input logic [7:0] tb_);
        exp_t e;
        e.a = ta;
        e.b = tb_;
        if (tb_ == 8'd0) begin
            e.q = (w == 4) ? 8'h0f : 8'hff;
            e.r = ta;
            e.z = 1'b1;
        end else begin
            e.q = ta / tb_;
            e.r = ta % tb_;
            e.z = 1'b0;
        end
        if (w == 4) begin
            q4.push_back(e);
            npush4++;
        end else begin
            q8.push_back(e);
            npush8++;
        end
    endtask

    // Single operation: accept, then measure latency and busy cycles
    task automatic go(input int w, input logic [7:0] ta, input logic [7:0] tb_);
        int n;
        int nb;
        @(negedge clk);
        if (w == 4) begin
            a4 = ta[3:0]; b4 = tb_[3:0]; start4 = 1'b1;
        end else begin
            a8 = ta; b8 = tb_; start8 = 1'b1;
        end
        push(w, ta, tb_);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        n  = 1;
        nb = 0;
        while (!((w == 4) ? done4 : done8) && n < 40) begin
            if ((w == 4) ? busy4 : busy8) nb++;
            @(negedge clk);
            n++;
        end
        chk("latency", n, (tb_ == 8'd0) ? 2 : w + 1);
        chk("busy_cycles", nb, (tb_ == 8'd0) ? 0 : w);
    endtask

    // Scoreboard for the 4-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done4) begin
            ndone4++;
            chk("excl4", {31'd0, busy4}, 0);
            if (q4.size() == 0) begin
                chk("done4_spurious", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("quot4", {28'd0, quot4}, {24'd0, e.q});
                chk("rem4", {28'd0, rem4}, {24'd0, e.r});
                chk("dbz4", {31'd0, dbz4}, {31'd0, e.z});
            end
        end
    end

    // Scoreboard for the 8-bit instance, including the division identity
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            ndone8++;
            done_cycs.push_back(cyc);
            chk("excl8", {31'd0, busy8}, 0);
            if (q8.size() == 0) begin
                chk("done8_spurious", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("quot8", {24'd0, quot8}, {24'd0, e.q});
                chk("rem8", {24'd0, rem8}, {24'd0, e.r});
                chk("dbz8", {31'd0, dbz8}, {31'd0, e.z});
                if (e.b != 8'd0) begin
                    chk("ident8", 32'(quot8) * 32'(e.b) + 32'(rem8), {24'd0, e.a});
                    chk("rem_lt_b8", {31'd0, rem8 < e.b}, 1);
                end
            end
        end
    end

    initial begin
        int  n;
        bit  dropped;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset4", {busy4, done4, dbz4, quot4, rem4}, 0);
        chk("reset8", {busy8, done8, dbz8, quot8, rem8}, 0);

        // DATAWIDTH=4 basic, boundaries, divide by zero
        go(4, 8'd13, 8'd3);
        go(4, 8'd15, 8'd1);
        go(4, 8'd2,  8'd9);
        go(4, 8'd0,  8'd5);
        go(4, 8'd7,  8'd0);
        go(4, 8'd8,  8'd2);

        // DATAWIDTH=8 back-to-back with start held high
        done_cycs.delete();
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        push(8, 8'd200, 8'd7);
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd16;
        push(8, 8'd255, 8'd16);
        n = 0;
        dropped = 1'b0;
        while (done_cycs.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (!dropped && done8) begin
                @(negedge clk);
                n++;
                start8 = 1'b0;
                dropped = 1'b1;
            end
        end
        @(negedge clk);
        chk("b2b_count", done_cycs.size(), 2);
        if (done_cycs.size() >= 2)
            chk("b2b_spacing", done_cycs[1] - done_cycs[0], 9);

        // Start pulsed mid-CALC is ignored
        @(negedge clk);
        a8 = 8'd60; b8 = 8'd7; start8 = 1'b1;
        push(8, 8'd60, 8'd7);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (20) @(negedge clk);

        // Reset two cycles after accepting 100/3
        a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst8", {busy8, done8, dbz8, quot8, rem8}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        go(8, 8'd100, 8'd3);

        // Random operands, including occasional zero divisors
        for (int i = 0; i < 1000; i++) begin
            go(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("dones4", ndone4, npush4);
        chk("dones8", ndone8, npush8);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
